// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hazard_ctrl_pkg
// Brief   : Shared state encoding and constants for the hazard controller.
// Revision: 1.0 - initial release
// ============================================================================
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        ERROR    = 2'd3
    } state_e;

    localparam logic [4:0] c_reg_zero = 5'd0;

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : hazard_ctrl_if
// Brief   : Hazard-detect inputs and per-stage pipeline-register controls.
// Revision: 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if;
    logic       start_i;
    logic       idex_memread_i;
    logic [4:0] idex_rt_i;
    logic [4:0] ifid_rs_i;
    logic [4:0] ifid_rt_i;
    logic       branch_taken_i;
    logic       mem_req_i;
    logic       mem_ack_i;
    logic       pc_write_o;
    logic       ifid_write_o;
    logic       ifid_flush_o;
    logic       idex_write_o;
    logic       idex_bubble_o;
    logic       exmem_write_o;
    logic       memwb_bubble_o;

    // master: pipeline/environment side, slave: the controller
    modport master (
        output start_i, idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i,
               branch_taken_i, mem_req_i, mem_ack_i,
        input  pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o,
               idex_bubble_o, exmem_write_o, memwb_bubble_o
    );

    modport slave (
        input  start_i, idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i,
               branch_taken_i, mem_req_i, mem_ack_i,
        output pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o,
               idex_bubble_o, exmem_write_o, memwb_bubble_o
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : sat_counter
// Brief   : Up-counter that sticks at all-ones; cleared only by reset.
// Revision: 1.0 - initial release
// ============================================================================
module sat_counter
    import hazard_ctrl_pkg::*;
#(
    parameter int W = 16
) (
    input  wire logic         clk_i,
    input  wire logic         rst_i,
    input  wire logic         inc_i,
    output logic [W-1:0]      cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : hazard_ctrl
// Brief   : 5-stage pipeline sequencing: load-use, branch flush, memory wait.
// Revision: 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    hazard_ctrl_if.slave          hz,
    output logic                  err_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
);

    localparam logic [7:0] c_timeout = 8'(MEM_TIMEOUT);

    state_e     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       w_load_use;
    logic       w_stall_inc;

    assign w_load_use = hz.idex_memread_i && (hz.idex_rt_i != c_reg_zero) &&
                        ((hz.idex_rt_i == hz.ifid_rs_i) || (hz.idex_rt_i == hz.ifid_rt_i));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        wait_d            = wait_q;
        w_stall_inc       = 1'b0;
        hz.pc_write_o     = 1'b0;
        hz.ifid_write_o   = 1'b0;
        hz.ifid_flush_o   = 1'b0;
        hz.idex_write_o   = 1'b0;
        hz.idex_bubble_o  = 1'b0;
        hz.exmem_write_o  = 1'b0;
        hz.memwb_bubble_o = 1'b0;

        case (state_q)
            IDLE: begin
                if (hz.start_i) state_d = RUN;
            end
            RUN: begin
                if (hz.mem_req_i && !hz.mem_ack_i) begin
                    hz.memwb_bubble_o = 1'b1;
                    w_stall_inc       = 1'b1;
                    state_d           = MEM_WAIT;
                    wait_d            = 8'd1;
                end else if (w_load_use) begin
                    hz.idex_write_o   = 1'b1;
                    hz.idex_bubble_o  = 1'b1;
                    hz.exmem_write_o  = 1'b1;
                    w_stall_inc       = 1'b1;
                end else begin
                    hz.pc_write_o     = 1'b1;
                    hz.ifid_write_o   = 1'b1;
                    hz.idex_write_o   = 1'b1;
                    hz.exmem_write_o  = 1'b1;
                    hz.ifid_flush_o   = hz.branch_taken_i;
                end
            end
            MEM_WAIT: begin
                if (hz.mem_ack_i) begin
                    // retiring cycle: the whole pipe advances, no hazard checks
                    hz.pc_write_o     = 1'b1;
                    hz.ifid_write_o   = 1'b1;
                    hz.idex_write_o   = 1'b1;
                    hz.exmem_write_o  = 1'b1;
                    state_d           = RUN;
                    wait_d            = 8'd0;
                end else begin
                    hz.memwb_bubble_o = 1'b1;
                    w_stall_inc       = 1'b1;
                    wait_d            = wait_q + 8'd1;
                    if (wait_d == c_timeout) state_d = ERROR;
                end
            end
            default: ;
        endcase
    end

    assign err_o = (state_q == ERROR);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (w_stall_inc),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (hz.ifid_flush_o),
        .cnt_o (flush_cnt_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_hazard_ctrl
// Brief   : Self-checking bench: directed scenarios plus randomized traffic.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             err_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    hazard_ctrl_if hz ();

    hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .hz          (hz.slave),
        .err_o       (err_o),
        .stall_cnt_o (stall_cnt_o),
        .flush_cnt_o (flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    // Abstract model: running/errored flags, count of waits on the current access.
    bit m_run, m_err;
    int m_waits, m_stall, m_flush;
    logic [6:0] e_ctl;
    bit e_stall, e_memstall, e_flush;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] dut_ctl();
        return {hz.pc_write_o, hz.ifid_write_o, hz.ifid_flush_o, hz.idex_write_o,
                hz.idex_bubble_o, hz.exmem_write_o, hz.memwb_bubble_o};
    endfunction

    // Expected controls packed as {pc, ifid_w, ifid_flush, idex_w, idex_bubble, exmem_w, memwb_bubble}
    task automatic model_outputs();
        bit hit;
        e_ctl = 7'b0; e_stall = 0; e_memstall = 0; e_flush = 0;
        hit = hz.idex_memread_i && hz.idex_rt_i != 0 &&
              (hz.idex_rt_i == hz.ifid_rs_i || hz.idex_rt_i == hz.ifid_rt_i);
        if (!rst_i || !m_run || m_err) return;
        if (m_waits > 0) begin
            if (hz.mem_ack_i) e_ctl = 7'b1101010;
            else begin e_ctl = 7'b0000001; e_memstall = 1; end
        end else if (hz.mem_req_i && !hz.mem_ack_i) begin
            e_ctl = 7'b0000001; e_memstall = 1;
        end else if (hit) begin
            e_ctl = 7'b0001110; e_stall = 1;
        end else begin
            e_ctl = 7'b1101010;
            if (hz.branch_taken_i) begin e_ctl[4] = 1'b1; e_flush = 1; end
        end
        if (e_memstall) e_stall = 1;
    endtask

    task automatic model_reset();
        m_run = 0; m_err = 0; m_waits = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic eval(input string tag);
        #1;
        model_outputs();
        check({tag, "_ctl"}, 32'(dut_ctl()), 32'(e_ctl));
        check({tag, "_err"}, 32'(err_o), 32'(m_err));
        check({tag, "_scnt"}, 32'(stall_cnt_o), 32'(m_stall));
        check({tag, "_fcnt"}, 32'(flush_cnt_o), 32'(m_flush));
    endtask

    task automatic tick();
        model_outputs();
        @(posedge clk_i);
        if (rst_i) begin
            if (e_stall && m_stall < CNT_MAX) m_stall++;
            if (e_flush && m_flush < CNT_MAX) m_flush++;
            if (!m_run && !m_err) begin
                if (hz.start_i) m_run = 1;
            end else if (m_run && !m_err) begin
                if (e_memstall) begin
                    m_waits++;
                    if (m_waits >= MEM_TIMEOUT) begin m_err = 1; m_run = 0; m_waits = 0; end
                end else if (m_waits > 0) m_waits = 0;
            end
        end
        @(negedge clk_i);
    endtask

    task automatic set_in(input bit st, input bit mr, input int rt, input int rs,
                          input int frt, input bit br, input bit rq, input bit ak);
        hz.start_i = st; hz.idex_memread_i = mr; hz.idex_rt_i = 5'(rt);
        hz.ifid_rs_i = 5'(rs); hz.ifid_rt_i = 5'(frt); hz.branch_taken_i = br;
        hz.mem_req_i = rq; hz.mem_ack_i = ak;
    endtask

    task automatic reset_and_start();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        rst_i = 1'b0; model_reset();
        tick();
        rst_i = 1'b1;
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        eval("rs_idle");
        tick();
    endtask

    initial begin
        rst_i = 1'b0;
        model_reset();
        set_in(1, 1, 8, 8, 0, 1, 1, 0);
        // 1: reset held for three cycles, controls forced low
        repeat (3) begin @(negedge clk_i); eval("t1_rst"); end
        rst_i = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        eval("t1_idle");
        check("t1_idle_pc", 32'(hz.pc_write_o), 0);
        check("t1_idle_cnt", 32'(stall_cnt_o), 0);
        tick();
        hz.start_i = 1'b1;
        eval("t1_start");
        tick();
        eval("t1_run");
        check("t1_run_pc", 32'(hz.pc_write_o), 1);
        tick();

        // 2: load-use hit on rs, then same with rt=0
        set_in(0, 1, 8, 8, 3, 0, 0, 0);
        eval("t2_hit");
        check("t2_pc", 32'(hz.pc_write_o), 0);
        check("t2_ifid", 32'(hz.ifid_write_o), 0);
        check("t2_bub", 32'(hz.idex_bubble_o), 1);
        tick();
        set_in(0, 1, 0, 0, 0, 0, 0, 0);
        eval("t2_r0");
        check("t2_scnt", 32'(stall_cnt_o), 1);
        check("t2_r0_pc", 32'(hz.pc_write_o), 1);
        tick();

        // 3: load-use beats a simultaneous taken branch
        set_in(0, 1, 9, 2, 9, 1, 0, 0);
        eval("t3_both");
        check("t3_noflush", 32'(hz.ifid_flush_o), 0);
        check("t3_bub", 32'(hz.idex_bubble_o), 1);
        tick();
        set_in(0, 0, 9, 2, 9, 1, 0, 0);
        eval("t3_br");
        check("t3_flush", 32'(hz.ifid_flush_o), 1);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        eval("t3_after");
        check("t3_fcnt", 32'(flush_cnt_o), 1);
        tick();

        // 4: three wait cycles, ack on the fourth
        reset_and_start();
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            eval("t4_wait");
            check("t4_exmem", 32'(hz.exmem_write_o), 0);
            check("t4_mwb", 32'(hz.memwb_bubble_o), 1);
            tick();
        end
        hz.mem_ack_i = 1'b1;
        eval("t4_ack");
        check("t4_ack_ctl", 32'(dut_ctl()), 32'(7'b1101010));
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        eval("t4_post");
        check("t4_scnt", 32'(stall_cnt_o), 3);
        tick();

        // 5: timeout into the sticky error state
        reset_and_start();
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            eval("t5_wait");
            check("t5_noerr", 32'(err_o), 0);
            tick();
        end
        hz.mem_ack_i = 1'b1;
        eval("t5_err");
        check("t5_err_o", 32'(err_o), 1);
        check("t5_frozen", 32'(dut_ctl()), 0);
        tick();
        eval("t5_stuck");
        check("t5_still", 32'(err_o), 1);
        tick();

        // 6: asynchronous reset in the middle of a memory wait
        reset_and_start();
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        eval("t6_w0"); tick();
        eval("t6_w1");
        #1 rst_i = 1'b0;
        #1;
        model_reset();
        check("t6_mwb", 32'(hz.memwb_bubble_o), 0);
        check("t6_scnt", 32'(stall_cnt_o), 0);
        check("t6_err", 32'(err_o), 0);
        hz.mem_ack_i = 1'b1;
        tick();
        rst_i = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        eval("t6_idle");
        tick();

        // randomized traffic with occasional resets
        reset_and_start();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) reset_and_start();
            set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 4,
                   1'($urandom_range(0, 1)));
            eval("rnd");
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage datapath. Generates per-stage write-enable, bubble and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. Covers load-use hazards, taken-branch flush and multi-cycle data-memory handshakes, with a timeout watchdog and saturating stall/flush counters. Sits beside the pipeline registers and is the only block that drives their enables.

Parameters:
MEM_TIMEOUT, 16, maximum consecutive wait cycles for one data-memory access before the error state; legal range 2..255.
CNT_W, 16, width of the performance counters.

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
start_i  in  1  CPU run enable; level, sampled in IDLE
idex_memread_i  in  1  instruction in EX is a load
idex_rt_i  in  5  destination register of the load in EX
ifid_rs_i  in  5  rs of the instruction in ID
ifid_rt_i  in  5  rt of the instruction in ID
branch_taken_i  in  1  branch resolved taken in ID
mem_req_i  in  1  EX/MEM holds a load or store (mem read|write)
mem_ack_i  in  1  data memory completes the access this cycle
pc_write_o  out  1  PC load enable
ifid_write_o  out  1  IF/ID load enable
ifid_flush_o  out  1  IF/ID loads a NOP
idex_write_o  out  1  ID/EX load enable
idex_bubble_o  out  1  ID/EX loads all-zero control (bubble)
exmem_write_o  out  1  EX/MEM load enable
memwb_bubble_o  out  1  MEM/WB loads zero wb control
err_o  out  1  memory timeout; sticky
stall_cnt_o  out  CNT_W  cycles with any stall
flush_cnt_o  out  CNT_W  cycles with ifid_flush_o=1

Behaviour:
- States: IDLE, RUN, MEM_WAIT, ERROR. Registered state; control outputs are combinational from state and inputs (zero-latency, same-cycle effect on the pipeline registers).
- Reset, asynchronous: state=IDLE, wait counter=0, err_o=0, both perf counters=0.
- IDLE, and reset held low: all *_write_o=0, bubble/flush outputs=0. start_i=1 -> RUN on the next edge.
- ERROR: same output values as IDLE, with err_o=1. The only exit is reset.
- Memory stall, the condition RUN && mem_req_i && !mem_ack_i, or MEM_WAIT && !mem_ack_i:
  - pc_write_o=ifid_write_o=idex_write_o=exmem_write_o=0
  - memwb_bubble_o=1
  - all other hazard outputs suppressed
- Transitions:
  - RUN -> MEM_WAIT on mem_req_i && !mem_ack_i. Wait counter loads 1.
  - MEM_WAIT and mem_ack_i -> RUN. That cycle is not a stall: all enables=1 and the access retires.
  - MEM_WAIT and !mem_ack_i: wait counter increments. When the counter equals MEM_TIMEOUT and ack is still low -> ERROR.
  - mem_req_i && mem_ack_i in RUN: single-cycle access, no stall.
- Load-use, evaluated in RUN only when no memory stall:
  - Condition: idex_memread_i && idex_rt_i!=0 && (idex_rt_i==ifid_rs_i || idex_rt_i==ifid_rt_i).
  - Outputs: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, idex_write_o=1, exmem_write_o=1.
- Branch flush, in RUN with no memory stall and no load-use: branch_taken_i=1 -> ifid_flush_o=1, all enables=1.
  - Load-use with a simultaneous taken branch: load-use wins and the flush is suppressed. The branch re-resolves next cycle.
- Default in RUN: all enables=1, bubble/flush=0.
- stall_cnt_o increments on every cycle with a memory stall or load-use stall. flush_cnt_o increments on every cycle with ifid_flush_o=1. Both saturate at 2^CNT_W-1 and do not count in IDLE or ERROR.
- Reset asserted mid-MEM_WAIT: immediate return to IDLE with outputs as in IDLE. Any pending ack is ignored.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, RUN=2'd1, MEM_WAIT=2'd2, ERROR=2'd3) and the register-zero constant 5'd0.
- One natural sub-module, sat_counter (parameter W; inc, clear via async reset; saturating). Instantiate it twice for the perf counters.
- Hazard compare logic and the FSM stay inline.

Test Plan:
1. Reset low for 3 cycles, then high with start_i=0: all enables 0, err_o=0, counters 0. Then start_i=1: pc_write_o=1 from the next cycle.
2. RUN with idex_memread_i=1, idex_rt_i=8, ifid_rs_i=8, mem_req_i=0:
   - same cycle: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1.
   - stall_cnt_o=1 on the following edge.
   - repeat with idex_rt_i=0: no stall.
3. Load-use hit plus branch_taken_i=1 in the same cycle: ifid_flush_o=0 and idex_bubble_o=1. Next cycle with the hazard cleared and the branch still taken: ifid_flush_o=1, then flush_cnt_o=1.
4. mem_req_i=1 with mem_ack_i low for 3 cycles, high on the 4th:
   - exmem_write_o=0 and memwb_bubble_o=1 for 3 cycles.
   - all enables 1 on the ack cycle.
   - stall_cnt_o=3 afterwards.
5. MEM_TIMEOUT=4, mem_req_i=1, ack never asserted: err_o=1 after the 4th wait cycle and outputs frozen. A later mem_ack_i=1 has no effect. Only reset low clears err_o.
6. Reset pulsed low mid-MEM_WAIT: state returns to IDLE asynchronously, counters=0, memwb_bubble_o=0.
